// File: rtl/demux41_tdm.sv
// demux41_tdm: receive end of a 4:1 TDM link, one word per channel per frame.
// Define DEMUX41_PARITY_EN to add a trailing even-parity round and a perr port.
module demux41_tdm #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             Y,
    output logic             S0,
    output logic             S1,
    output logic [WIDTH-1:0] O0,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [WIDTH-1:0] O3,
`ifdef DEMUX41_PARITY_EN
    output logic [3:0]       perr,
`endif
    output logic [3:0]       valid
);

`ifdef DEMUX41_PARITY_EN
    localparam int ROUNDS = WIDTH + 1;
`else
    localparam int ROUNDS = WIDTH;
`endif
    localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int BCW = $clog2(ROUNDS);
    localparam logic [HCW-1:0] HLAST = HCW'(HOLD - 1);
    localparam logic [BCW-1:0] BLAST = BCW'(ROUNDS - 1);

    logic [HCW-1:0]            hcnt_q, hcnt_d;
    logic [1:0]                slot_q, slot_d;
    logic [BCW-1:0]            bcnt_q, bcnt_d;
    logic [3:0][WIDTH-1:0]     sh_q, sh_d;
    logic [3:0][WIDTH-1:0]     o_q, o_d;
    logic [3:0]                valid_q, valid_d;
    logic                      sample;
    logic [WIDTH-1:0]          shifted;
`ifdef DEMUX41_PARITY_EN
    logic [3:0]                perr_q, perr_d;
`endif

    // Slot/round counters, per-channel shift registers and word capture.
    always_comb begin
        hcnt_d  = hcnt_q;
        slot_d  = slot_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        o_d     = o_q;
        valid_d = '0;
        sample  = 1'b0;
        shifted = {sh_q[slot_q][WIDTH-2:0], Y};
`ifdef DEMUX41_PARITY_EN
        perr_d  = '0;
`endif
        if (sync) begin
            hcnt_d = '0;
            slot_d = '0;
            bcnt_d = '0;
            sh_d   = '0;
        end else if (en) begin
            if (hcnt_q == HLAST) begin
                hcnt_d = '0;
                sample = 1'b1;
                slot_d = slot_q + 2'd1;
                if (slot_q == 2'd3) begin
                    bcnt_d = (bcnt_q == BLAST) ? '0 : bcnt_q + 1'b1;
                end
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
        if (sample) begin
`ifdef DEMUX41_PARITY_EN
            // The final round carries parity; the word itself is already complete.
            if (bcnt_q == BLAST) begin
                o_d[slot_q]     = sh_q[slot_q];
                valid_d[slot_q] = 1'b1;
                perr_d[slot_q]  = (^sh_q[slot_q]) ^ Y;
            end else begin
                sh_d[slot_q] = shifted;
            end
`else
            sh_d[slot_q] = shifted;
            if (bcnt_q == BLAST) begin
                o_d[slot_q]     = shifted;
                valid_d[slot_q] = 1'b1;
            end
`endif
        end
    end

    // State register; reset drops any partial frame and clears the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q  <= '0;
            slot_q  <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            o_q     <= '0;
            valid_q <= '0;
        end else begin
            hcnt_q  <= hcnt_d;
            slot_q  <= slot_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            o_q     <= o_d;
            valid_q <= valid_d;
        end
    end

`ifdef DEMUX41_PARITY_EN
    // Parity error strobe, aligned with valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= '0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign perr = perr_q;
`endif

    assign S0    = slot_q[0];
    assign S1    = slot_q[1];
    assign O0    = o_q[0];
    assign O1    = o_q[1];
    assign O2    = o_q[2];
    assign O3    = o_q[3];
    assign valid = valid_q;

endmodule

// File: tb/tb_demux41_tdm.sv
// tb_demux41_tdm: two DUTs (HOLD=1, HOLD=3) fed by modelled remote 4:1 muxes.
// Scoreboard of expected words; honours DEMUX41_PARITY_EN.
module tb_demux41_tdm;

`ifdef DEMUX41_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int W = 8;
    localparam int ROUNDS = W + PAR;

    typedef struct {
        int       ch;
        logic [7:0] w;
        logic     pe;
        int       cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sync = 1'b0;
    logic       y_a [2];
    logic       s0_a [2];
    logic       s1_a [2];
    logic [7:0] o_a [2][4];
    logic [3:0] valid_a [2];
`ifdef DEMUX41_PARITY_EN
    logic [3:0] perr_a [2];
`endif

    int         ntests = 0;
    int         nfail = 0;
    int         cyc = 0;
    int         cnt [2] = '{0, 0};
    logic [7:0] word [2][4];
    logic       bad [2][4];
    logic [7:0] om [2][4];
    bit         rnd_on = 1'b0;
    exp_t       q0 [$];
    exp_t       q1 [$];
    int         en_start = 0;
    int         first_v [2] = '{-1, -1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    demux41_tdm #(.WIDTH(W), .HOLD(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .Y(y_a[0]),
        .S0(s0_a[0]), .S1(s1_a[0]),
        .O0(o_a[0][0]), .O1(o_a[0][1]), .O2(o_a[0][2]), .O3(o_a[0][3]),
`ifdef DEMUX41_PARITY_EN
        .perr(perr_a[0]),
`endif
        .valid(valid_a[0])
    );

    demux41_tdm #(.WIDTH(W), .HOLD(3)) u_h3 (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .Y(y_a[1]),
        .S0(s0_a[1]), .S1(s1_a[1]),
        .O0(o_a[1][0]), .O1(o_a[1][1]), .O2(o_a[1][2]), .O3(o_a[1][3]),
`ifdef DEMUX41_PARITY_EN
        .perr(perr_a[1]),
`endif
        .valid(valid_a[1])
    );

    function automatic int hold_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Remote mux: Y carries the selected channel's current bit; wrong value
    // on all but the last cycle of each slot.
    always @* begin
        for (int i = 0; i < 2; i++) begin
            int   h;
            int   rd;
            int   sl;
            logic b;
            h  = hold_of(i);
            rd = cnt[i] / (4 * h);
            sl = int'({s1_a[i], s0_a[i]});
            if (rd < W) b = word[i][sl][W-1-rd];
            else        b = (^word[i][sl]) ^ bad[i][sl];
            y_a[i] = ((cnt[i] % h) == h - 1) ? b : ~b;
        end
    end

    // Reference model: position in frame from a plain enabled-cycle count.
    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        int   h;
        int   fl;
        int   sl;
        int   rd;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= 0;
                for (int k = 0; k < 4; k++) om[i][k] <= '0;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                h  = hold_of(i);
                fl = 4 * ROUNDS * h;
                sl = (cnt[i] / h) % 4;
                rd = cnt[i] / (4 * h);
                if (sync) begin
                    cnt[i] <= 0;
                end else if (en) begin
                    cnt[i] <= (cnt[i] + 1) % fl;
                    if ((cnt[i] % h) == h - 1 && rd == ROUNDS - 1) begin
                        e.ch  = sl;
                        e.w   = word[i][sl];
                        e.pe  = bad[i][sl];
                        e.cyc = cyc + 1;
                        om[i][sl] <= word[i][sl];
                        if (i == 0) q0.push_back(e);
                        else        q1.push_back(e);
                    end
                    if (cnt[i] + 1 == fl && rnd_on) begin
                        for (int k = 0; k < 4; k++) begin
                            word[i][k] <= 8'($urandom);
                            bad[i][k]  <= (PAR == 1) && ($urandom_range(3) == 0);
                        end
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a DUT raises valid.
    always @(negedge clk) begin
        exp_t e;
        int   qs;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("sel%0d", i), 32'({s1_a[i], s0_a[i]}),
                    32'((cnt[i] / hold_of(i)) % 4));
                for (int k = 0; k < 4; k++)
                    chk($sformatf("hold%0d_O%0d", i, k), 32'(o_a[i][k]), 32'(om[i][k]));
                qs = (i == 0) ? q0.size() : q1.size();
                if (valid_a[i] != 4'b0) begin
                    if (first_v[i] < 0) first_v[i] = cyc;
                    chk($sformatf("onehot%0d", i), 32'($countones(valid_a[i])), 32'd1);
                    if (qs == 0) begin
                        chk($sformatf("unexpected_valid%0d", i), 32'(valid_a[i]), 32'd0);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("vch%0d", i), 32'(valid_a[i]), 32'(4'b1 << e.ch));
                        chk($sformatf("word%0d", i), 32'(o_a[i][e.ch]), 32'(e.w));
                        chk($sformatf("vcyc%0d", i), 32'(cyc), 32'(e.cyc));
`ifdef DEMUX41_PARITY_EN
                        chk($sformatf("perr%0d", i), 32'(perr_a[i]),
                            32'({3'b0, e.pe} << e.ch));
`endif
                    end
                end else if (qs != 0) begin
                    e = (i == 0) ? q0[0] : q1[0];
                    if (e.cyc <= cyc) begin
                        chk($sformatf("missed_valid%0d", i), 32'(cyc), 32'(e.cyc));
                        if (i == 0) void'(q0.pop_front());
                        else        void'(q1.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_sel%0d", tag, i), 32'({s1_a[i], s0_a[i]}), 32'd0);
            chk($sformatf("%s_valid%0d", tag, i), 32'(valid_a[i]), 32'd0);
            for (int k = 0; k < 4; k++)
                chk($sformatf("%s_O%0d%0d", tag, i, k), 32'(o_a[i][k]), 32'd0);
        end
    endtask

    initial begin
        logic [1:0] sel_hold [2];
        logic [7:0] fixed [4];
        fixed = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) begin
                word[i][k] = fixed[k];
                bad[i][k]  = (PAR == 1) && (k == 1);
            end

        step(3);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step(1);
        en = 1'b1;
        en_start = cyc + 1;

        // First frame of both links with the fixed words.
        step(4 * ROUNDS * 3 + 4);
        chk("lat_h1", 32'(first_v[0] - en_start), 32'(4 * (ROUNDS - 1)));
        chk("lat_h3", 32'(first_v[1] - en_start), 32'(12 * (ROUNDS - 1) + 2));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("basic_h3_O%0d", k), 32'(o_a[1][k]), 32'(fixed[k]));
            chk($sformatf("basic_h1_O%0d", k), 32'(o_a[0][k]), 32'(fixed[k]));
        end
        rnd_on = 1'b1;

        // Directed 5-cycle enable gap: selects must not move.
        step(7);
        sel_hold[0] = {s1_a[0], s0_a[0]};
        sel_hold[1] = {s1_a[1], s0_a[1]};
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(1);
            for (int i = 0; i < 2; i++)
                chk($sformatf("gap_sel%0d", i), 32'({s1_a[i], s0_a[i]}), 32'(sel_hold[i]));
        end
        en = 1'b1;

        // Directed mid-frame sync.
        step(10);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        step(4 * ROUNDS * 3 + 10);

        // Randomized en/sync traffic.
        for (int c = 0; c < 1500; c++) begin
            en   = ($urandom_range(7) != 0);
            sync = ($urandom_range(99) == 0);
            step(1);
        end
        en = 1'b1;
        sync = 1'b0;
        step(4 * ROUNDS + 5);

        // Asynchronous reset between edges.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_rst");
        step(2);
        rst_n = 1'b1;

        for (int c = 0; c < 1000; c++) begin
            en   = ($urandom_range(5) != 0);
            sync = ($urandom_range(149) == 0);
            step(1);
        end
        en = 1'b1;
        sync = 1'b0;
        step(4 * ROUNDS * 3 * 2 + 10);
        chk("drain_q0", 32'(q0.size()), 32'd0);
        chk("drain_q1", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
